// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Valid/ready word intake with a one-word holding register for gapless streaming.
module piso_serializer #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam int               OUT_IDX  = LSB_FIRST ? 0 : WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             pend_full_r, pend_full_s;
  logic             active_s;
  logic             accept_s;
  logic             last_s;

  // Move the word one position toward the output end, zero-filling behind it.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    if (LSB_FIRST) begin
      return {1'b0, v[WIDTH-1:1]};
    end else begin
      return {v[WIDTH-2:0], 1'b0};
    end
  endfunction

  assign active_s   = (state_r == SHIFT);
  assign din_ready  = rst & ~pend_full_r;
  assign accept_s   = din_valid & din_ready;
  assign last_s     = active_s & (cnt_r == CNT_LAST);
  assign sout       = active_s & shreg_r[OUT_IDX];
  assign sout_valid = active_s;
  assign sout_last  = last_s;
  assign busy       = active_s | pend_full_r;

  // Next-state logic: load, shift, reload from pend or din, or drop to idle.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    pend_s      = pend_r;
    cnt_s       = cnt_r;
    pend_full_s = pend_full_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shreg_s = din;
          cnt_s   = {CNT_W{1'b0}};
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (en && last_s) begin
          // pend has priority; din only bypasses when pend is empty
          if (pend_full_r) begin
            shreg_s     = pend_r;
            cnt_s       = {CNT_W{1'b0}};
            pend_full_s = 1'b0;
          end else if (accept_s) begin
            shreg_s = din;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end else begin
          if (en) begin
            shreg_s = shift_word(shreg_r);
            cnt_s   = cnt_r + CNT_ONE;
          end else begin
            shreg_s = shreg_r;
          end
          if (accept_s) begin
            pend_s      = din;
            pend_full_s = 1'b1;
          end else begin
            pend_s = pend_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      pend_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      pend_full_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      pend_r      <= pend_s;
      cnt_r       <= cnt_s;
      pend_full_r <= pend_full_s;
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the serial sequence-detector FSM. It accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per enabled clock, LSB first by default, on `sout`, which drives the detector's `inp`. A one-word holding register allows back-to-back words to stream with no bubble between the last bit of one word and the first bit of the next.

## Interface
- `WIDTH`, 16, word width in bits (≥2).
- `LSB_FIRST`, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.

- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-low; one clock; sampled on posedge `clk`.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept `din` this cycle.
- `en`  in  1  advance enable; the current bit is consumed on a posedge where `en`=1.
- `sout`  out  1  current serial bit; goes to detector `inp`.
- `sout_valid`  out  1  `sout` carries a word bit.
- `sout_last`  out  1  current bit is the final bit of its word.
- `busy`  out  1  shift register or holding register occupied.

## Operation
- Storage: shift register `shreg`, bit counter `cnt` (0..WIDTH-1), `active` flag, holding register `pend`, and `pend_full` flag.
- `din_ready` = `rst` & !`pend_full`. Accept = `din_valid` & `din_ready` at a posedge.
- Output mapping:
  - `sout` = `shreg[0]` when LSB_FIRST=1; `shreg[WIDTH-1]` otherwise; 0 when !`active`.
  - `sout_valid` = `active`.
  - `sout_last` = `active` & (`cnt` == WIDTH-1).
  - `busy` = `active` | `pend_full`.
- States are IDLE (!`active`) and SHIFT (`active`).
- IDLE, on accept: load `shreg`←`din`, `cnt`←0, go to SHIFT.
- SHIFT, `en`=0: hold all state. `sout` is stable.
- SHIFT, `en`=1, not last bit: shift `shreg` one position toward the output end and zero-fill; `cnt`+1.
- SHIFT, `en`=1, last bit (`sout_last`), taking the first matching case:
  - `pend_full`: `shreg`←`pend`, `cnt`←0, `pend_full`←0, stay in SHIFT.
  - Accept this cycle with `pend` empty: `shreg`←`din`, `cnt`←0, stay in SHIFT. `din` bypasses `pend`.
  - Otherwise go to IDLE.
- SHIFT, accept while not consuming the last bit: `pend`←`din`, `pend_full`←1.
- An accept can never occur while `pend_full`=1. `din_ready` is 0 in that case, so no overflow exists.
- Counter wraps only by reload to 0. `cnt` never exceeds WIDTH-1.

## Timing
- Reset (`rst`=0 at a posedge): `active`, `pend_full`, `cnt`, `shreg`, and `pend` are all cleared.
  - Outputs while `rst`=0: `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0, `din_ready`=0.
  - After release, `din_ready`=1.
- Reset mid-word discards both the active word and the pending word. No partial bits are emitted afterward.
- Latency: word accepted at posedge N → bit 0 on `sout` with `sout_valid`=1 during the cycle after N.
  - With `en` held at 1, the last bit appears during cycle N+WIDTH.
- Throughput with `en`=1: one bit per clock. Consecutive words produce contiguous `sout_valid` with no idle cycle.
- `din_ready` drops the cycle after `pend` fills. It rises the cycle after `pend` drains into `shreg`.
- `sout` changes only on posedges where `en`=1, or on a load from IDLE. The detector may sample `sout` every clock.

## Test plan
- Reset, then word 16'h5772 with `en`=1 → 16 consecutive `sout_valid` cycles.
  - `sout` sequence: 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0.
  - `sout_last`=1 only on the 16th cycle; then `sout_valid`=0 and `busy`=0.
- Back-to-back: 16'h5772, then 16'hFFFF presented immediately → 32 contiguous valid cycles; bits 17–32 all 1.
  - `din_ready`=0 from the cycle after the second accept until the cycle after the first word's last bit.
- Stall: `en`=0 for 3 cycles while bit 5 of 16'h5772 is presented → `sout` holds 1 for 4 cycles.
  - Remaining bits are unchanged; 19 valid cycles total.
- Last-bit bypass: with `pend` empty, present 16'h0003 exactly on the `sout_last`&`en` cycle → accepted.
  - Next cycle `sout`=1, `cnt`=0, with no gap.
- Reset mid-operation: assert `rst`=0 at bit 8 with a word pending.
  - Next cycle: `sout_valid`=0, `sout`=0, `busy`=0.
  - After release: `din_ready`=1 and no residual bits are emitted.
- LSB_FIRST=0, word 16'h8001 → `sout` sequence 1, fourteen 0s, 1; `sout_last` on the final 1.
